mem_write_checker: RTL and testbench

Synthesizable, parametrised self-check monitor for the processor data-memory write port. It generalises the bench's single "address 84 / data 7" success check to a loadable ordered table of up to DEPTH expected (address, data) stores, with a tolerated scratch address, a configurable width, and a cycle timeout. It sits beside `top`, snooping `memwrite`/`dataadr`/`writedata`. Its pass/fail status can be read by benches or routed to board LEDs.

---
 rtl/mem_write_checker.sv | 166 ++++++++++++++++
 tb/tb_mem_write_checker.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_checker.sv
// Data-memory store monitor: checks snooped stores against an ordered table.
// Optional RUN timeout watchdog is built when MWC_TIMEOUT_EN is defined.
module mem_write_checker #(
  parameter  int ADDR_W      = 32,
  parameter  int DATA_W      = 32,
  parameter  int DEPTH       = 4,
  parameter  int IGNORE_ADDR = 80,
  parameter  int TIMEOUT     = 1024,
  localparam int IDX_W       = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W:0]    exp_count,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [ADDR_W-1:0] exp_addr,
  input  logic [DATA_W-1:0] exp_data,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              busy,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_code,
  output logic [IDX_W:0]    match_count,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_PASS, S_FAIL
  } state_t;

  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(DEPTH);

  state_t            r_state;
  logic [ADDR_W-1:0] r_tab_addr [DEPTH];
  logic [DATA_W-1:0] r_tab_data [DEPTH];
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W:0]    r_cnt;
  logic [IDX_W:0]    r_match;
  logic              r_busy;
  logic              r_pass;
  logic              r_fail;
  logic [1:0]        r_code;
  logic [ADDR_W-1:0] r_faddr;
  logic [DATA_W-1:0] r_fdata;

  logic           w_hit;
  logic           w_ign;
  logic           w_last;
  logic           w_cnt_bad;
  logic           w_tmo;
  logic [IDX_W:0] w_match_inc;

  assign w_hit = memwrite
              && (dataadr == r_tab_addr[r_ptr])
              && (writedata == r_tab_data[r_ptr]);
  assign w_ign = (dataadr == ADDR_W'(IGNORE_ADDR));
  assign w_match_inc = r_match + (IDX_W+1)'(1);
  assign w_last = (w_match_inc == r_cnt);
  assign w_cnt_bad = (exp_count == '0) || (exp_count > CNT_MAX);

`ifdef MWC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] r_timer;

  // Saturates so a late non-final match still times out next cycle.
  assign w_tmo = (r_timer >= TW'(TIMEOUT-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_timer <= '0;
    else if (r_state != S_RUN)
      r_timer <= '0;
    else if (r_timer != TW'(TIMEOUT))
      r_timer <= r_timer + TW'(1);
  end
`else
  assign w_tmo = 1'b0;
`endif

  // Table is writable only outside RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_tab_addr[i] <= '0;
        r_tab_data[i] <= '0;
      end
    end else if (exp_we && !r_busy) begin
      r_tab_addr[exp_idx] <= exp_addr;
      r_tab_data[exp_idx] <= exp_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_match <= '0;
      r_busy  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_code  <= 2'd0;
      r_faddr <= '0;
      r_fdata <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_hit) begin
            r_ptr   <= r_ptr + IDX_W'(1);
            r_match <= w_match_inc;
            if (w_last) begin
              r_state <= S_PASS;
              r_busy  <= 1'b0;
              r_pass  <= 1'b1;
            end
          end else if (memwrite && !w_ign) begin
            r_state <= S_FAIL;
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
            r_code  <= 2'd1;
            r_faddr <= dataadr;
            r_fdata <= writedata;
          end else if (w_tmo) begin
            r_state <= S_FAIL;
            r_busy  <= 1'b0;
            r_fail  <= 1'b1;
            r_code  <= 2'd2;
          end
        end
        default: begin
          if (start) begin
            r_ptr   <= '0;
            r_match <= '0;
            r_pass  <= 1'b0;
            r_faddr <= '0;
            r_fdata <= '0;
            if (w_cnt_bad) begin
              r_state <= S_FAIL;
              r_fail  <= 1'b1;
              r_code  <= 2'd3;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_cnt   <= exp_count;
              r_fail  <= 1'b0;
              r_code  <= 2'd0;
            end
          end
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign fail_code   = r_code;
  assign match_count = r_match;
  assign fail_addr   = r_faddr;
  assign fail_data   = r_fdata;

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker (DEPTH=4, TIMEOUT=16).
// Timeout scenario depends on whether MWC_TIMEOUT_EN is defined.
module tb_mem_write_checker;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    exp_count = '0;
  logic          exp_we = 1'b0;
  logic [1:0]    exp_idx = '0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;
  logic          memwrite = 1'b0;
  logic [AW-1:0] dataadr = '0;
  logic [DW-1:0] writedata = '0;
  logic          busy;
  logic          pass;
  logic          fail;
  logic [1:0]    fail_code;
  logic [2:0]    match_count;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  int n_chk = 0;
  int n_fail = 0;

  mem_write_checker #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(4),
    .IGNORE_ADDR(80), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .exp_count(exp_count), .exp_we(exp_we),
    .exp_idx(exp_idx), .exp_addr(exp_addr),
    .exp_data(exp_data), .memwrite(memwrite),
    .dataadr(dataadr), .writedata(writedata),
    .busy(busy), .pass(pass), .fail(fail),
    .fail_code(fail_code), .match_count(match_count),
    .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int i, input int a, input int d);
    exp_we = 1'b1;
    exp_idx = 2'(i);
    exp_addr = AW'(a);
    exp_data = DW'(d);
    tick();
    exp_we = 1'b0;
  endtask

  task automatic store(input int a, input int d);
    memwrite = 1'b1;
    dataadr = AW'(a);
    writedata = DW'(d);
    tick();
    memwrite = 1'b0;
  endtask

  task automatic launch(input int cnt);
    exp_count = 3'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_seq();
    load(0, 0, 1);
    load(1, 4, 2);
    load(2, 8, 3);
    load(3, 12, 4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_chk++;
    if ({busy, pass, fail, fail_code, match_count} !== 8'd0
        || fail_addr !== '0 || fail_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: b%0b p%0b f%0b c%0d m%0d a%0d d%0d, want all 0",
               busy, pass, fail, fail_code, match_count, fail_addr, fail_data);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ignore_then_target();
    load(0, 84, 7);
    // Store coincident with start must not be checked.
    memwrite = 1'b1;
    dataadr = 1;
    writedata = 1;
    launch(1);
    memwrite = 1'b0;
    n_chk++;
    if (busy !== 1'b1 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL launch_busy: busy=%0b fail=%0b, want 1/0", busy, fail);
    end
    store(80, 3);
    n_chk++;
    if (busy !== 1'b1 || pass !== 1'b0 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_store: b%0b p%0b f%0b, want 1/0/0", busy, pass, fail);
    end
    store(84, 7);
    n_chk++;
    if (pass !== 1'b1 || fail !== 1'b0 || busy !== 1'b0 || match_count !== 3'd1) begin
      n_fail++;
      $display("FAIL target_pass: p%0b f%0b b%0b m%0d, want 1/0/0/1",
               pass, fail, busy, match_count);
    end
    store(99, 99);
    n_chk++;
    if (pass !== 1'b1 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_store: p%0b f%0b, want 1/0", pass, fail);
    end
  endtask

  task automatic test_mismatch();
    launch(1);
    n_chk++;
    if (pass !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL relaunch_clear: pass=%0b busy=%0b, want 0/1", pass, busy);
    end
    store(84, 6);
    n_chk++;
    if (fail !== 1'b1 || fail_code !== 2'd1 || fail_addr !== 84
        || fail_data !== 6 || busy !== 1'b0 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL data_mismatch: f%0b c%0d a%0d d%0d b%0b p%0b, want 1/1/84/6/0/0",
               fail, fail_code, fail_addr, fail_data, busy, pass);
    end
  endtask

  task automatic test_sequence();
    load_seq();
    launch(4);
    store(0, 1);
    store(80, 9);
    store(4, 2);
    store(8, 3);
    n_chk++;
    if (match_count !== 3'd3 || busy !== 1'b1 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_mid: m%0d b%0b p%0b, want 3/1/0", match_count, busy, pass);
    end
    store(12, 4);
    n_chk++;
    if (pass !== 1'b1 || match_count !== 3'd4 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_pass: p%0b m%0d f%0b, want 1/4/0", pass, match_count, fail);
    end
    launch(4);
    store(4, 2);
    n_chk++;
    if (fail_code !== 2'd1 || match_count !== 3'd0 || fail_addr !== 4
        || fail_data !== 2 || pass !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_order: c%0d m%0d a%0d d%0d p%0b, want 1/0/4/2/0",
               fail_code, match_count, fail_addr, fail_data, pass);
    end
  endtask

  task automatic test_bad_count();
    launch(0);
    n_chk++;
    if (fail !== 1'b1 || fail_code !== 2'd3 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_count0: f%0b c%0d b%0b, want 1/3/0", fail, fail_code, busy);
    end
    launch(5);
    n_chk++;
    if (fail !== 1'b1 || fail_code !== 2'd3 || busy !== 1'b0 || fail_addr !== 0) begin
      n_fail++;
      $display("FAIL bad_count5: f%0b c%0d b%0b a%0d, want 1/3/0/0",
               fail, fail_code, busy, fail_addr);
    end
  endtask

  task automatic test_write_with_start();
    load(0, 84, 7);
    exp_we = 1'b1;
    exp_idx = 0;
    exp_addr = 20;
    exp_data = 5;
    launch(1);
    // Table write during RUN must be dropped.
    exp_addr = 84;
    exp_data = 7;
    tick();
    exp_we = 1'b0;
    store(20, 5);
    n_chk++;
    if (pass !== 1'b1 || fail !== 1'b0 || match_count !== 3'd1) begin
      n_fail++;
      $display("FAIL write_with_start: p%0b f%0b m%0d, want 1/0/1",
               pass, fail, match_count);
    end
  endtask

  task automatic test_timeout();
`ifdef MWC_TIMEOUT_EN
    launch(1);
    repeat (15) tick();
    n_chk++;
    if (fail !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_early: f%0b b%0b at edge 15, want 0/1", fail, busy);
    end
    tick();
    n_chk++;
    if (fail !== 1'b1 || fail_code !== 2'd2 || busy !== 1'b0
        || fail_addr !== 0 || fail_data !== 0) begin
      n_fail++;
      $display("FAIL timeout_fire: f%0b c%0d b%0b a%0d d%0d, want 1/2/0/0/0",
               fail, fail_code, busy, fail_addr, fail_data);
    end
`else
    int drops;
    drops = 0;
    launch(1);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy !== 1'b1 || fail !== 1'b0) drops++;
    end
    n_chk++;
    if (drops !== 0) begin
      n_fail++;
      $display("FAIL no_timeout: busy dropped %0d of 100 cycles, want 0", drops);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif
  endtask

  task automatic test_reset_midrun();
    load_seq();
    launch(4);
    store(0, 1);
    n_chk++;
    if (match_count !== 3'd1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_pre: m%0d b%0b, want 1/1", match_count, busy);
    end
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if ({busy, pass, fail, fail_code, match_count} !== 8'd0) begin
      n_fail++;
      $display("FAIL async_reset: b%0b p%0b f%0b c%0d m%0d, want all 0",
               busy, pass, fail, fail_code, match_count);
    end
    tick();
    reset = 1'b0;
    tick();
    // Cleared table holds (0,0) in entry 0.
    launch(1);
    store(0, 0);
    n_chk++;
    if (pass !== 1'b1 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL table_cleared: p%0b f%0b, want 1/0", pass, fail);
    end
    load_seq();
    launch(4);
    store(0, 1);
    store(4, 2);
    store(8, 3);
    store(12, 4);
    n_chk++;
    if (pass !== 1'b1 || match_count !== 3'd4 || fail !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_run: p%0b m%0d f%0b, want 1/4/0",
               pass, match_count, fail);
    end
  endtask

  initial begin
    test_reset();
    test_ignore_then_target();
    test_mismatch();
    test_sequence();
    test_bad_count();
    test_write_with_start();
    test_timeout();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
